// File: rtl/gpi_filter_bank.sv
// Multi-channel GPI conditioner: gate, synchronise, glitch-filter and edge-detect
// each pad input, then latch qualifying edges as sticky pending flags behind one IRQ.
module gpi_filter_bank #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_CH-1:0]     pad_di_i,
    input  logic [N_CH-1:0]     ie_i,
    input  logic [CNT_W-1:0]    filt_len_i,
    input  logic [2*N_CH-1:0]   edge_mode_i,
    input  logic [N_CH-1:0]     irq_clr_i,
    output logic [N_CH-1:0]     level_o,
    output logic [N_CH-1:0]     edge_o,
    output logic [N_CH-1:0]     irq_pending_o,
    output logic                irq_o
);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  edge_q;
    logic [N_CH-1:0]  pend_q;
    logic [CNT_W-1:0] cnt_q [N_CH];

    // Mode bit 0 enables rising edges, bit 1 enables falling edges.
    function automatic logic qualify_edge(input logic new_level, input logic [1:0] mode);
        return new_level ? mode[0] : mode[1];
    endfunction

    // Synchroniser: gating ahead of the first flop keeps a disabled pad from toggling it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_di_i & ie_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Glitch filter and edge detect; >= lets a shortened L take effect on an in-flight count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            edge_q  <= '0;
            for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                edge_q[c] <= 1'b0;
                if (!ie_i[c]) begin
                    cnt_q[c]   <= '0;
                    level_q[c] <= 1'b0;
                end else if (s[c] == level_q[c]) begin
                    cnt_q[c] <= '0;
                end else if (cnt_q[c] >= filt_len_i) begin
                    cnt_q[c]   <= '0;
                    level_q[c] <= s[c];
                    edge_q[c]  <= qualify_edge(s[c], edge_mode_i[2*c +: 2]);
                end else begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // Pending flags: a set in the same cycle as a clear takes precedence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= edge_q | (pend_q & ~irq_clr_i);
        end
    end

    assign level_o       = level_q;
    assign edge_o        = edge_q;
    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;

endmodule

// File: tb/tb_gpi_filter_bank.sv
// Directed bench for gpi_filter_bank: reset, latency, glitch rejection, L=0 tracking,
// enable gating and pending set/clear collision.
module tb_gpi_filter_bank;

    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH-1:0]     pad_di;
    logic [N_CH-1:0]     ie;
    logic [CNT_W-1:0]    filt_len;
    logic [2*N_CH-1:0]   edge_mode;
    logic [N_CH-1:0]     irq_clr;
    logic [N_CH-1:0]     level;
    logic [N_CH-1:0]     edge_p;
    logic [N_CH-1:0]     pend;
    logic                irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpi_filter_bank #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pad_di_i(pad_di), .ie_i(ie),
        .filt_len_i(filt_len), .edge_mode_i(edge_mode), .irq_clr_i(irq_clr),
        .level_o(level), .edge_o(edge_p), .irq_pending_o(pend), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic pv [0:40];

    initial begin
        rst       = 1'b1;
        pad_di    = '0;
        ie        = '1;
        filt_len  = 8'd3;
        edge_mode = 16'h0055;
        irq_clr   = '0;
        tick(3);
        rst    = 1'b0;
        pad_di = '1;
        tick(10);
        chk("pre_reset_level", level, 8'hFF);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst_level", level, 8'h00);
        chk("rst_edge", edge_p, 8'h00);
        chk("rst_pend", pend, 8'h00);
        chk("rst_irq", irq, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        tick(5);
        chk("rel_level_t5", level, 8'h00);
        chk("rel_edge_t5", edge_p, 8'h00);
        tick();
        chk("rel_level_t6", level, 8'hFF);
        chk("rel_edge_t6", edge_p, 8'h0F);
        tick();
        chk("rel_edge_t7", edge_p, 8'h00);
        chk("rel_pend_t7", pend, 8'h0F);
        chk("rel_irq_t7", irq, 1'b1);
        irq_clr = '1;
        tick();
        irq_clr = '0;
        chk("clr_pend", pend, 8'h00);
        chk("clr_irq", irq, 1'b0);

        // latency on ch0, L=3, mode 01; falling edges must not set pending
        pad_di = '0;
        tick(8);
        chk("fall_level", level, 8'h00);
        chk("fall_no_pend", pend, 8'h00);
        pad_di = 8'h01;
        tick(5);
        chk("lat_level_t5", level, 8'h00);
        tick();
        chk("lat_level_t6", level, 8'h01);
        chk("lat_edge_t6", edge_p, 8'h01);
        tick();
        chk("lat_pend_t7", pend, 8'h01);
        chk("lat_irq_t7", irq, 1'b1);
        chk("lat_edge_t7", edge_p, 8'h00);

        // glitch rejection on ch0, mode 11
        pad_di = '0;
        tick(8);
        edge_mode[1:0] = 2'b11;
        irq_clr = '1;
        tick();
        irq_clr = '0;
        begin
            logic seen_lvl;
            int   n_edges;
            seen_lvl = 1'b0;
            n_edges  = 0;
            pad_di[0] = 1'b1;
            for (int i = 0; i < 13; i++) begin
                if (i == 3) pad_di[0] = 1'b0;
                tick();
                seen_lvl |= level[0];
                n_edges  += int'(edge_p[0]);
            end
            chk("glitch3_level", seen_lvl, 1'b0);
            chk("glitch3_edges", n_edges, 0);
            chk("glitch3_pend", pend[0], 1'b0);
        end
        pad_di[0] = 1'b1;
        tick(4);
        chk("pulse4_level_t4", level[0], 1'b0);
        pad_di[0] = 1'b0;
        tick(2);
        chk("pulse4_level_t6", level[0], 1'b1);
        chk("pulse4_edge_t6", edge_p[0], 1'b1);
        tick();
        chk("pulse4_edge_t7", edge_p[0], 1'b0);
        tick(2);
        chk("pulse4_level_t9", level[0], 1'b1);
        chk("pulse4_edge_t9", edge_p[0], 1'b0);
        tick();
        chk("pulse4_level_t10", level[0], 1'b0);
        chk("pulse4_edge_t10", edge_p[0], 1'b1);
        chk("pulse4_pend", pend[0], 1'b1);

        // L=0 pass-through on ch1, falling edges only
        filt_len = 8'd0;
        edge_mode[3:2] = 2'b10;
        tick(4);
        pv[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            pv[k] = (((k - 1) / 4) % 2) == 0;
            pad_di[1] = pv[k];
            tick();
            if (k >= 3) begin
                chk($sformatf("l0_level_k%0d", k), level[1], pv[k-2]);
                chk($sformatf("l0_edge_k%0d", k), edge_p[1], pv[k-3] & ~pv[k-2]);
            end
        end
        tick(3);
        chk("l0_pend", pend[1], 1'b1);

        // enable gating on ch2
        pad_di[2] = 1'b1;
        tick(3);
        chk("ie_level_up", level[2], 1'b1);
        chk("ie_edge_up", edge_p[2], 1'b1);
        tick();
        chk("ie_pend_up", pend[2], 1'b1);
        ie[2] = 1'b0;
        tick();
        chk("ie_level_off", level[2], 1'b0);
        chk("ie_edge_off", edge_p[2], 1'b0);
        chk("ie_pend_keep", pend[2], 1'b1);
        tick(4);
        chk("ie_edge_later", edge_p[2], 1'b0);
        chk("ie_pend_later", pend[2], 1'b1);

        // set/clear collision on ch3
        irq_clr = '1;
        tick();
        irq_clr = '0;
        chk("col_irq_idle", irq, 1'b0);
        pad_di[3] = 1'b1;
        tick(3);
        chk("col_edge", edge_p[3], 1'b1);
        irq_clr[3] = 1'b1;
        tick();
        chk("col_pend_set_wins", pend[3], 1'b1);
        chk("col_irq_set", irq, 1'b1);
        tick();
        irq_clr[3] = 1'b0;
        chk("col_pend_cleared", pend[3], 1'b0);
        chk("col_irq_cleared", irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
